// File: rtl/ili_pkg.sv
// Shared types and constants for the ILI9325 8080-style bus engine.
package ili_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_DONE
   } ili_state_e;

   localparam logic RS_INDEX = 1'b0;
   localparam logic RS_DATA  = 1'b1;

   function automatic bit bus_w_legal(input int unsigned w);
      return (w == 8) || (w == 16);
   endfunction

   function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/ili_bus_ctrl_if.sv
// Command stream, read-back and LCD pin bundle for ili_bus_ctrl.
interface ili_bus_ctrl_if #(
   parameter int unsigned BUS_W = 8,
   parameter int unsigned REP_W = 16
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_rs;
   logic             cmd_rd;
   logic [15:0]      cmd_data;
   logic [REP_W-1:0] cmd_rep;
   logic             rd_valid;
   logic [15:0]      rd_data;
   logic             busy;
   logic             ILI_nCS;
   logic             ILI_RS;
   logic             ILI_nWR;
   logic             ILI_nRD;
   logic [BUS_W-1:0] ILI_DB_o;
   logic             ILI_DB_oe;
   logic [BUS_W-1:0] ILI_DB_i;

   modport master (
      output cmd_valid, cmd_rs, cmd_rd, cmd_data, cmd_rep, ILI_DB_i,
      input  cmd_ready, rd_valid, rd_data, busy,
             ILI_nCS, ILI_RS, ILI_nWR, ILI_nRD, ILI_DB_o, ILI_DB_oe
   );

   modport slave (
      input  cmd_valid, cmd_rs, cmd_rd, cmd_data, cmd_rep, ILI_DB_i,
      output cmd_ready, rd_valid, rd_data, busy,
             ILI_nCS, ILI_RS, ILI_nWR, ILI_nRD, ILI_DB_o, ILI_DB_oe
   );
endinterface

// File: rtl/ili_bus_ctrl.sv
// 8080-style write/read engine for the ILI9325 bus with programmable timing,
// 8/16-bit beats, hardware repeat fill and read-back. DB tristate lives above.
module ili_bus_ctrl
   import ili_pkg::*;
#(
   parameter int unsigned BUS_W      = 8,
   parameter int unsigned T_SETUP    = 2,
   parameter int unsigned T_STROBE   = 3,
   parameter int unsigned T_RDSTROBE = 8,
   parameter int unsigned T_HOLD     = 2,
   parameter int unsigned REP_W      = 16
) (
   input logic          clk_100,
   input logic          reset,
   ili_bus_ctrl_if.slave bus
);

   localparam int unsigned T_MAX = max4(T_SETUP, T_STROBE, T_RDSTROBE, T_HOLD);
   localparam int unsigned CNT_W = $clog2(T_MAX + 1);

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [REP_W-1:0] rep_t;

   localparam cnt_t C_ONE      = cnt_t'(1);
   localparam cnt_t C_SETUP    = cnt_t'(T_SETUP);
   localparam cnt_t C_STROBE   = cnt_t'(T_STROBE);
   localparam cnt_t C_RDSTROBE = cnt_t'(T_RDSTROBE);
   localparam cnt_t C_HOLD     = cnt_t'(T_HOLD);
   localparam rep_t R_ONE      = rep_t'(1);
   localparam logic LAST_BEAT  = (BUS_W == 8) ? 1'b1 : 1'b0;

   if (!bus_w_legal(BUS_W)) begin : g_bad_bus_w
      $error("ili_bus_ctrl: BUS_W must be 8 or 16");
   end

   ili_state_e  state_q, state_d;
   cnt_t        cnt_q, cnt_d;
   logic        beat_q, beat_d;
   logic        rs_q, rs_d;
   logic        rd_q, rd_d;
   logic [15:0] data_q, data_d;
   rep_t        rep_q, rep_d;
   logic [15:0] rd_data_q, rd_data_d;
   logic        rd_valid_q, rd_valid_d;
   logic        busy_q, busy_d;
   logic        ncs_q, ncs_d;
   logic        rs_pin_q, rs_pin_d;
   logic        nwr_q, nwr_d;
   logic        nrd_q, nrd_d;
   logic [BUS_W-1:0] db_o_q, db_o_d;
   logic        db_oe_q, db_oe_d;

   logic        cmd_ready;
   logic        active_d;
   logic [7:0]  byte_sel;

   assign cmd_ready = (state_q == ST_IDLE) && !reset;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      beat_d     = beat_q;
      rs_d       = rs_q;
      rd_d       = rd_q;
      data_d     = data_q;
      rep_d      = rep_q;
      rd_data_d  = rd_data_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid && cmd_ready) begin
               rs_d    = bus.cmd_rs;
               rd_d    = bus.cmd_rd;
               data_d  = bus.cmd_data;
               rep_d   = bus.cmd_rd ? '0 : bus.cmd_rep;
               beat_d  = 1'b0;
               cnt_d   = C_SETUP;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (cnt_q == C_ONE) begin
               state_d = ST_STROBE;
               cnt_d   = rd_q ? C_RDSTROBE : C_STROBE;
            end else begin
               cnt_d = cnt_q - C_ONE;
            end
         end
         ST_STROBE: begin
            if (cnt_q == C_ONE) begin
               state_d = ST_HOLD;
               cnt_d   = C_HOLD;
               // 8-bit reads arrive high byte first
               if (rd_q) begin
                  if (BUS_W == 16)  rd_data_d = 16'(bus.ILI_DB_i);
                  else if (!beat_q) rd_data_d = {bus.ILI_DB_i[7:0], rd_data_q[7:0]};
                  else              rd_data_d = {rd_data_q[15:8], bus.ILI_DB_i[7:0]};
               end
            end else begin
               cnt_d = cnt_q - C_ONE;
            end
         end
         ST_HOLD: begin
            if (cnt_q != C_ONE) begin
               cnt_d = cnt_q - C_ONE;
            end else if (beat_q != LAST_BEAT) begin
               beat_d  = 1'b1;
               cnt_d   = C_SETUP;
               state_d = ST_SETUP;
            end else if (rep_q != '0) begin
               rep_d   = rep_q - R_ONE;
               beat_d  = 1'b0;
               cnt_d   = C_SETUP;
               state_d = ST_SETUP;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Pins are registered from next-state so they change exactly with the state
      active_d   = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
      ncs_d      = !active_d;
      rs_pin_d   = active_d && rs_d;
      nwr_d      = !((state_d == ST_STROBE) && !rd_d);
      nrd_d      = !((state_d == ST_STROBE) && rd_d);
      db_oe_d    = active_d && !rd_d;
      byte_sel   = beat_d ? data_d[7:0] : data_d[15:8];
      db_o_d     = '0;
      if (db_oe_d) db_o_d = (BUS_W == 8) ? BUS_W'(byte_sel) : BUS_W'(data_d);
      busy_d     = active_d;
      rd_valid_d = (state_d == ST_DONE) && rd_d;
   end

   always_ff @(posedge clk_100) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         beat_q     <= 1'b0;
         rs_q       <= 1'b0;
         rd_q       <= 1'b0;
         data_q     <= '0;
         rep_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         ncs_q      <= 1'b1;
         rs_pin_q   <= 1'b0;
         nwr_q      <= 1'b1;
         nrd_q      <= 1'b1;
         db_o_q     <= '0;
         db_oe_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         beat_q     <= beat_d;
         rs_q       <= rs_d;
         rd_q       <= rd_d;
         data_q     <= data_d;
         rep_q      <= rep_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         busy_q     <= busy_d;
         ncs_q      <= ncs_d;
         rs_pin_q   <= rs_pin_d;
         nwr_q      <= nwr_d;
         nrd_q      <= nrd_d;
         db_o_q     <= db_o_d;
         db_oe_q    <= db_oe_d;
      end
   end

   assign bus.cmd_ready = cmd_ready;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_data   = rd_data_q;
   assign bus.busy      = busy_q;
   assign bus.ILI_nCS   = ncs_q;
   assign bus.ILI_RS    = rs_pin_q;
   assign bus.ILI_nWR   = nwr_q;
   assign bus.ILI_nRD   = nrd_q;
   assign bus.ILI_DB_o  = db_o_q;
   assign bus.ILI_DB_oe = db_oe_q;

endmodule

// File: tb/tb_ili_bus_ctrl.sv
// Scoreboard bench for ili_bus_ctrl: a 16-bit instance and an 8-bit instance with REP_W=4.
module tb_ili_bus_ctrl;
   import ili_pkg::*;

   typedef struct {
      bit          rd;
      logic        rs;
      logic [15:0] db;
      int          len;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ili_bus_ctrl_if #(.BUS_W(16), .REP_W(16)) b16 ();
   ili_bus_ctrl_if #(.BUS_W(8),  .REP_W(4))  b8 ();

   ili_bus_ctrl #(.BUS_W(16), .T_SETUP(2), .T_STROBE(3), .T_RDSTROBE(8), .T_HOLD(2), .REP_W(16))
      u16 (.clk_100(clk), .reset(rst), .bus(b16));
   ili_bus_ctrl #(.BUS_W(8), .T_SETUP(2), .T_STROBE(3), .T_RDSTROBE(8), .T_HOLD(2), .REP_W(4))
      u8 (.clk_100(clk), .reset(rst), .bus(b8));

   int total = 0;
   int bad   = 0;

   beat_t       exp_beat [2][$];
   int          exp_cs   [2][$];
   logic [15:0] exp_rd   [2][$];
   logic [15:0] bm       [2][$];
   logic [15:0] dbi      [2];

   logic        p_ncs [2], p_nwr [2], p_nrd [2], p_rs [2], p_oe [2];
   logic        p_rdv [2], p_rdy [2], p_busy [2];
   logic [15:0] p_db [2], p_rdd [2];

   assign p_ncs[0] = b16.ILI_nCS;   assign p_ncs[1] = b8.ILI_nCS;
   assign p_nwr[0] = b16.ILI_nWR;   assign p_nwr[1] = b8.ILI_nWR;
   assign p_nrd[0] = b16.ILI_nRD;   assign p_nrd[1] = b8.ILI_nRD;
   assign p_rs[0]  = b16.ILI_RS;    assign p_rs[1]  = b8.ILI_RS;
   assign p_oe[0]  = b16.ILI_DB_oe; assign p_oe[1]  = b8.ILI_DB_oe;
   assign p_db[0]  = b16.ILI_DB_o;  assign p_db[1]  = {8'h00, b8.ILI_DB_o};
   assign p_rdv[0] = b16.rd_valid;  assign p_rdv[1] = b8.rd_valid;
   assign p_rdd[0] = b16.rd_data;   assign p_rdd[1] = b8.rd_data;
   assign p_rdy[0] = b16.cmd_ready; assign p_rdy[1] = b8.cmd_ready;
   assign p_busy[0] = b16.busy;     assign p_busy[1] = b8.busy;
   assign b16.ILI_DB_i = dbi[0];
   assign b8.ILI_DB_i  = dbi[1][7:0];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: strobe beats, nCS low runs and read-back pulses against the queues
   int    slen [2] = '{0, 0};
   int    cslen [2] = '{0, 0};
   int    hirun [2] = '{0, 0};
   int    last_gap [2] = '{0, 0};
   int    overlap = 0;
   beat_t cap [2];
   beat_t mon_e;
   logic [15:0] mon_rd;
   int    mon_cs;

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (p_oe[d] && !p_nrd[d]) overlap++;
         if (!p_nwr[d] || !p_nrd[d]) begin
            if (slen[d] == 0) begin
               cap[d].rd = !p_nrd[d];
               cap[d].rs = p_rs[d];
               cap[d].db = p_db[d];
               if (!p_nrd[d] && bm[d].size() != 0) dbi[d] = bm[d].pop_front();
            end
            slen[d]++;
         end else if (slen[d] != 0) begin
            if (exp_beat[d].size() == 0) chk("beat_extra", 1, 0);
            else begin
               mon_e = exp_beat[d].pop_front();
               chk("beat_dir", 32'(cap[d].rd), 32'(mon_e.rd));
               chk("beat_rs", 32'(cap[d].rs), 32'(mon_e.rs));
               if (!mon_e.rd) chk("beat_db", 32'(cap[d].db), 32'(mon_e.db));
               chk("beat_len", slen[d], mon_e.len);
            end
            slen[d] = 0;
         end
         if (!p_ncs[d]) begin
            if (cslen[d] == 0) begin
               last_gap[d] = hirun[d];
               hirun[d] = 0;
            end
            cslen[d]++;
         end else begin
            if (cslen[d] != 0) begin
               if (exp_cs[d].size() == 0) chk("cs_extra", 1, 0);
               else begin
                  mon_cs = exp_cs[d].pop_front();
                  chk("cs_len", cslen[d], mon_cs);
               end
               cslen[d] = 0;
            end
            hirun[d]++;
         end
         if (p_rdv[d]) begin
            if (exp_rd[d].size() == 0) chk("rdv_extra", 1, 0);
            else begin
               mon_rd = exp_rd[d].pop_front();
               chk("rd_data", 32'(p_rdd[d]), 32'(mon_rd));
            end
         end
      end
   end

   task automatic drive(input int d, input logic v, input logic rs, input logic rd,
                        input logic [15:0] data, input int rep);
      if (d == 0) begin
         b16.cmd_valid = v; b16.cmd_rs = rs; b16.cmd_rd = rd;
         b16.cmd_data = data; b16.cmd_rep = 16'(rep);
      end else begin
         b8.cmd_valid = v; b8.cmd_rs = rs; b8.cmd_rd = rd;
         b8.cmd_data = data; b8.cmd_rep = 4'(rep);
      end
   endtask

   // Offers one command and returns 1 time unit after the accepting edge
   task automatic issue(input int d, input logic rs, input logic rd, input logic [15:0] data,
                        input int rep, input bit push, input bit keep);
      int n = 0;
      int nb = (d == 1) ? 2 : 1;
      int words = rd ? 1 : rep + 1;
      beat_t b;
      if (push) begin
         for (int w = 0; w < words; w++)
            for (int k = 0; k < nb; k++) begin
               b.rd  = rd;
               b.rs  = rs;
               b.db  = (nb == 1) ? data : ((k == 0) ? {8'h00, data[15:8]} : {8'h00, data[7:0]});
               b.len = rd ? 8 : 3;
               exp_beat[d].push_back(b);
            end
         exp_cs[d].push_back(words * nb * (rd ? 12 : 7));
      end
      drive(d, 1'b1, rs, rd, data, rep);
      while (!p_rdy[d] && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", 32'(p_rdy[d]), 1);
      chk("accept_idle_busy", 32'(p_busy[d]), 0);
      @(posedge clk);
      #1;
      if (!keep) drive(d, 1'b0, 1'b0, 1'b0, 16'h0, 0);
   endtask

   task automatic wait_idle(input int d);
      int n = 0;
      while (!p_rdy[d] && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("idle_reached", 32'(p_rdy[d]), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int nfall;
      logic prev;
      beat_t b;
      dbi[0] = '0;
      dbi[1] = '0;
      drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 0);
      drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 0);

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_ready", 32'(p_rdy[d]), 0);
         chk("rst_busy", 32'(p_busy[d]), 0);
         chk("rst_rdv", 32'(p_rdv[d]), 0);
         chk("rst_rdd", 32'(p_rdd[d]), 0);
         chk("rst_pins", {p_ncs[d], p_nwr[d], p_nrd[d], p_rs[d], p_oe[d]}, 5'b11100);
         chk("rst_db", 32'(p_db[d]), 0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready_after", {p_rdy[0], p_rdy[1]}, 2'b11);

      // T1: 16-bit index write, ready back 9 cycles after accept
      issue(0, RS_INDEX, 1'b0, 16'h0022, 0, 1'b1, 1'b0);
      n = 0;
      do begin @(negedge clk); n++; end while (!p_rdy[0] && n < 100);
      chk("t1_ready_lat", n, 9);

      // 16-bit read-back
      bm[0].push_back(16'hBEEF);
      exp_rd[0].push_back(16'hBEEF);
      issue(0, RS_DATA, 1'b1, 16'h0000, 0, 1'b1, 1'b0);
      wait_idle(0);

      // T2: 8-bit fill, 4 words of F800
      issue(1, RS_DATA, 1'b0, 16'hF800, 3, 1'b1, 1'b0);
      n = 0;
      do begin @(negedge clk); n++; end while (p_busy[1] && n < 500);
      chk("t2_busy_lat", n, 57);
      wait_idle(1);

      // T3: 8-bit read assembling 93 then 25; data and rep are ignored
      bm[1].push_back(16'h0093);
      bm[1].push_back(16'h0025);
      exp_rd[1].push_back(16'h9325);
      issue(1, RS_DATA, 1'b1, 16'hFFFF, 7, 1'b1, 1'b0);
      n = 0;
      nfall = 0;
      do begin @(negedge clk); if (p_oe[1]) nfall++; n++; end while (p_busy[1] && n < 500);
      chk("t3_oe_cycles", nfall, 0);
      wait_idle(1);

      // T4: cmd_valid held across three commands; nCS high for DONE plus the accepting IDLE
      issue(1, RS_DATA, 1'b0, 16'h1111, 0, 1'b1, 1'b1);
      issue(1, RS_DATA, 1'b0, 16'h2222, 0, 1'b1, 1'b1);
      @(negedge clk); #1;
      chk("t4_gap2", last_gap[1], 2);
      issue(1, RS_DATA, 1'b0, 16'h3333, 0, 1'b1, 1'b0);
      @(negedge clk); #1;
      chk("t4_gap3", last_gap[1], 2);
      wait_idle(1);

      // T5: reset in the first cycle of the second strobe of a rep=5 fill
      b.rd = 1'b0; b.rs = RS_DATA; b.db = 16'h0012; b.len = 3;
      exp_beat[1].push_back(b);
      b.db = 16'h0034; b.len = 1;
      exp_beat[1].push_back(b);
      exp_cs[1].push_back(10);
      issue(1, RS_DATA, 1'b0, 16'h1234, 5, 1'b0, 1'b0);
      n = 0;
      nfall = 0;
      prev = 1'b1;
      do begin
         @(negedge clk);
         if (!p_nwr[1] && prev) nfall++;
         prev = p_nwr[1];
         n++;
      end while (nfall < 2 && n < 100);
      chk("t5_reach_strobe2", nfall, 2);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_pins", {p_ncs[1], p_nwr[1], p_nrd[1], p_oe[1]}, 4'b1110);
      chk("t5_busy", 32'(p_busy[1]), 0);
      chk("t5_rdv", 32'(p_rdv[1]), 0);
      chk("t5_ready_in_rst", 32'(p_rdy[1]), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("t5_ready_after", 32'(p_rdy[1]), 1);
      issue(1, RS_INDEX, 1'b0, 16'h0022, 0, 1'b1, 1'b0);
      wait_idle(1);

      // T6: all-ones repeat on REP_W=4 gives 16 words and stops
      issue(1, RS_DATA, 1'b0, 16'hABCD, 15, 1'b1, 1'b0);
      n = 0;
      do begin @(negedge clk); n++; end while (p_busy[1] && n < 1000);
      chk("t6_busy_lat", n, 225);
      wait_idle(1);
      repeat (20) @(negedge clk);
      chk("t6_stay_idle", {p_rdy[1], p_busy[1], p_ncs[1]}, 3'b101);

      chk("oe_rd_overlap", overlap, 0);
      for (int d = 0; d < 2; d++) begin
         chk("beats_left", exp_beat[d].size(), 0);
         chk("cs_left", exp_cs[d].size(), 0);
         chk("rd_left", exp_rd[d].size(), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
